// File: rtl/prbs_pkg.sv
// prbs_pkg: shared PRBS15 (x^15+x^14+1) constants, next-state function and checker states
package prbs_pkg;
  localparam int PRBS15_W = 15;
  localparam int TAP_A = 14;
  localparam int TAP_B = 13;
  typedef enum logic {SEARCH, LOCKED} chk_state_t;
  function automatic logic [PRBS15_W-1:0] prbs15_next(input logic [PRBS15_W-1:0] s);
    return {s[PRBS15_W-2:0], s[TAP_A] ^ s[TAP_B]};
  endfunction
endpackage

// File: rtl/prbs15_checker.sv
// prbs15_checker: self-synchronising serial PRBS15 checker with lock FSM and saturating counters
module prbs15_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT    = 32,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             prbs_i,
  input  logic             valid_i,
  input  logic             resync_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] bit_cnt_o
);
  localparam logic [7:0] LOCK_V   = 8'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_V = 4'(UNLOCK_ERRS);
  chk_state_t state_q, state_d;
  logic [PRBS15_W-1:0] hist_q, hist_d, lfsr_q, lfsr_d;
  logic [3:0] fill_q, fill_d, cerr_q, cerr_d;
  logic [7:0] match_q, match_d;
  logic err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d, bit_cnt_q, bit_cnt_d;
  logic exp_s, exp_l;
  assign exp_s = hist_q[TAP_A] ^ hist_q[TAP_B];
  assign exp_l = lfsr_q[TAP_A] ^ lfsr_q[TAP_B];
  // next-state: resync beats valid data; clear beats any counter increment
  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    lfsr_d    = lfsr_q;
    fill_d    = fill_q;
    match_d   = match_q;
    cerr_d    = cerr_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    bit_cnt_d = bit_cnt_q;
    if (resync_i) begin
      state_d = SEARCH;
      hist_d  = '0;
      fill_d  = '0;
      match_d = '0;
      cerr_d  = '0;
    end else if (valid_i) begin
      hist_d = {hist_q[PRBS15_W-2:0], prbs_i};
      if (state_q == SEARCH) begin
        if (fill_q != 4'd15) fill_d = fill_q + 4'd1;
        else if (hist_q == '0 || prbs_i != exp_s) match_d = '0;
        else begin
          match_d = match_q + 8'd1;
          if (match_d == LOCK_V) begin
            state_d = LOCKED;
            lfsr_d  = {hist_q[PRBS15_W-2:0], prbs_i};
            cerr_d  = '0;
          end
        end
      end else begin
        lfsr_d    = prbs15_next(lfsr_q);
        bit_cnt_d = bit_cnt_q + CNT_W'(~&bit_cnt_q);
        if (prbs_i != exp_l) begin
          err_d     = 1'b1;
          err_cnt_d = err_cnt_q + CNT_W'(~&err_cnt_q);
          cerr_d    = cerr_q + 4'd1;
          if (cerr_d == UNLOCK_V) begin
            state_d = SEARCH;
            fill_d  = '0;
            match_d = '0;
            hist_d  = '0;
          end
        end else cerr_d = '0;
      end
    end
    if (clear_i) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end
  end
  // state and counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= SEARCH;
      hist_q    <= '0;
      lfsr_q    <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      cerr_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      lfsr_q    <= lfsr_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      cerr_q    <= cerr_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end
  assign locked_o  = (state_q == LOCKED);
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;
  assign bit_cnt_o = bit_cnt_q;
endmodule

// File: tb/tb_prbs15_checker.sv
// tb_prbs15_checker: directed checks of lock, error, resync, clear and reset behaviour
module tb_prbs15_checker;
  import prbs_pkg::*;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic prbs_i = 1'b0, valid_i = 1'b0, resync_i = 1'b0, clear_i = 1'b0;
  logic locked_o, err_o;
  logic [31:0] err_cnt_o, bit_cnt_o;
  logic [14:0] gen;
  int n_chk = 0, n_fail = 0;
  prbs15_checker dut (
    .clk_i(clk_i), .rst_i(rst_i), .prbs_i(prbs_i), .valid_i(valid_i),
    .resync_i(resync_i), .clear_i(clear_i), .locked_o(locked_o), .err_o(err_o),
    .err_cnt_o(err_cnt_o), .bit_cnt_o(bit_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic p, input logic v, input logic rs, input logic cl);
    @(negedge clk_i);
    prbs_i = p; valid_i = v; resync_i = rs; clear_i = cl;
    @(posedge clk_i);
    #1;
  endtask
  task automatic send(input logic flip, input logic cl);
    cyc(gen[14] ^ flip, 1'b1, 1'b0, cl);
    gen = prbs15_next(gen);
  endtask
  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1; valid_i = 1'b0; resync_i = 1'b0; clear_i = 1'b0; prbs_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask
  initial begin
    int nv, guard, pulses;
    logic seen;
    gen = 15'h7fff;
    do_reset();
    chk("rst_locked", 32'(locked_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_err_cnt", err_cnt_o, 0);
    chk("rst_bit_cnt", bit_cnt_o, 0);
    repeat (46) send(1'b0, 1'b0);
    chk("lock_46", 32'(locked_o), 0);
    send(1'b0, 1'b0);
    chk("lock_47", 32'(locked_o), 1);
    chk("lock_bit_cnt", bit_cnt_o, 0);
    for (int i = 0; i < 10; i++) begin
      send(1'b0, 1'b0);
      chk("bit_cnt_inc", bit_cnt_o, 32'(i + 1));
    end
    chk("clean_err_cnt", err_cnt_o, 0);
    repeat (142) send(1'b0, 1'b0);
    chk("pre_flip_err", 32'(err_o), 0);
    send(1'b1, 1'b0);
    chk("flip_err", 32'(err_o), 1);
    chk("flip_err_cnt", err_cnt_o, 1);
    chk("flip_locked", 32'(locked_o), 1);
    pulses = 0;
    repeat (5) begin
      send(1'b0, 1'b0);
      pulses += int'(err_o);
    end
    chk("flip_single_pulse", 32'(pulses), 0);
    send(1'b0, 1'b1);
    chk("clear_err_cnt", err_cnt_o, 0);
    chk("clear_bit_cnt", bit_cnt_o, 0);
    chk("clear_locked", 32'(locked_o), 1);
    repeat (3) send(1'b1, 1'b0);
    chk("burst3_locked", 32'(locked_o), 1);
    send(1'b1, 1'b0);
    chk("burst4_locked", 32'(locked_o), 0);
    chk("burst4_err", 32'(err_o), 1);
    chk("burst4_err_cnt", err_cnt_o, 4);
    chk("burst4_bit_cnt", bit_cnt_o, 4);
    repeat (46) send(1'b0, 1'b0);
    chk("relock_46", 32'(locked_o), 0);
    send(1'b0, 1'b0);
    chk("relock_47", 32'(locked_o), 1);
    chk("relock_err_cnt", err_cnt_o, 4);
    chk("relock_bit_cnt", bit_cnt_o, 4);
    do_reset();
    seen = 1'b0;
    repeat (200) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      seen |= locked_o;
    end
    repeat (200) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      seen |= locked_o;
    end
    chk("const_never_lock", 32'(seen), 0);
    chk("const_err_cnt", err_cnt_o, 0);
    chk("const_bit_cnt", bit_cnt_o, 0);
    do_reset();
    gen = 15'h7fff;
    nv = 0;
    guard = 0;
    while (nv < 46 && guard < 2000) begin
      guard++;
      if ($urandom_range(0, 1) == 1) begin
        send(1'b0, 1'b0);
        nv++;
      end else cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    end
    chk("rnd_valid_bits", 32'(nv), 46);
    chk("rnd_lock_46", 32'(locked_o), 0);
    repeat (3) cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b0);
    chk("rnd_lock_47", 32'(locked_o), 1);
    repeat (5) cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    chk("idle_bit_cnt", bit_cnt_o, 0);
    chk("idle_locked", 32'(locked_o), 1);
    repeat (3) send(1'b0, 1'b0);
    chk("pre_clr_bit_cnt", bit_cnt_o, 3);
    send(1'b1, 1'b1);
    chk("clr_err_pulse", 32'(err_o), 1);
    chk("clr_wins_err_cnt", err_cnt_o, 0);
    chk("clr_wins_bit_cnt", bit_cnt_o, 0);
    send(1'b0, 1'b0);
    chk("post_clr_err", 32'(err_o), 0);
    chk("post_clr_bit_cnt", bit_cnt_o, 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("resync_locked", 32'(locked_o), 0);
    chk("resync_bit_cnt", bit_cnt_o, 1);
    repeat (46) send(1'b0, 1'b0);
    chk("resync_46", 32'(locked_o), 0);
    send(1'b0, 1'b0);
    chk("resync_47", 32'(locked_o), 1);
    repeat (5) send(1'b0, 1'b0);
    chk("resync_bit_cnt2", bit_cnt_o, 6);
    send(1'b1, 1'b0);
    chk("pre_rst_err", 32'(err_o), 1);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("async_locked", 32'(locked_o), 0);
    chk("async_err", 32'(err_o), 0);
    chk("async_err_cnt", err_cnt_o, 0);
    chk("async_bit_cnt", bit_cnt_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
